// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the default burst limit and width helpers used to size the grant index,
// the beat counter and the optional stall counter.
package uart_arb_pkg;

  // Arbiter FSM: IDLE has no owner, XFER streams bytes from the owner.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_NUM_REQ   = 4;
  localparam int unsigned DEFAULT_MAX_BURST = 16;

  // Index width for a requester id; never below one bit.
  function automatic int unsigned grant_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. Given a request vector and a pointer,
// returns the first set request at or above the pointer, wrapping back to
// bit 0 when nothing at or above the pointer is set.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = grant_width(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick_src;

  // Bits at or above the pointer form the first search window.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (IDX_W'(gi) >= ptr);
    end
  endgenerate

  assign upper_req = req & upper_mask;
  // When nothing sits above the pointer, the wrapped search is simply the
  // lowest set bit of the whole vector.
  assign pick_src  = (|upper_req) ? upper_req : req;
  assign any_req   = |req;

  // Lowest set bit of the chosen window, as one-hot and as index.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX FIFO write port
// among NUM_REQ byte-stream requesters. An owner keeps the port until it
// sends a byte flagged last, or until MAX_BURST bytes force a release so the
// other requesters get a turn. One idle cycle always separates grants.
//
// Optional build macro UART_ARB_TIMEOUT_EN: adds the TIMEOUT_CYCLES
// parameter and the timeout_err output. An owner that holds valid low for
// TIMEOUT_CYCLES XFER cycles loses the grant and timeout_err pulses once.
// Without the macro a silent owner keeps the grant indefinitely.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         W_data,
  output logic                          wr_uart,
  input  logic                          tx_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int unsigned IDX_W = grant_width(NUM_REQ);
  localparam int unsigned CNT_W = count_width(MAX_BURST);

  localparam logic [0:0] IDLE = ARB_IDLE;
  localparam logic [0:0] XFER = ARB_XFER;

  // Count value held while the beat that completes a full burst is on the bus.
  localparam logic [CNT_W-1:0] LAST_BEAT_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_ID       = IDX_W'(NUM_REQ - 1);

  logic [0:0]            state_reg, state_next;
  logic [IDX_W-1:0]      grant_reg, grant_next;
  logic [NUM_REQ-1:0]    owner_oh_reg, owner_oh_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  logic                  in_xfer;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  beat;
  logic                  burst_done;
  logic                  timeout_hit;
  logic                  release_grant;
  logic [IDX_W-1:0]      ptr_after;
  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  // Unpack the flat data bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // The owner is kept both as an index (for muxing and grant_id) and as a
  // one-hot mask (for the ready vector and for qualifying valid/last).
  assign in_xfer     = (state_reg == XFER);
  assign owner_valid = |(req_valid & owner_oh_reg);
  assign owner_last  = |(req_last & owner_oh_reg);
  assign beat        = in_xfer && owner_valid && !tx_full;
  assign burst_done  = (count_reg == LAST_BEAT_CNT);
  assign ptr_after   = (grant_reg == LAST_ID) ? '0 : grant_reg + 1'b1;

  // Last byte, burst limit and stall timeout all collapse into one release,
  // so the pointer can only advance once per grant.
  assign release_grant = (beat && (owner_last || burst_done)) || timeout_hit;

  // Handshake outputs are purely combinational from the registered owner.
  assign req_ready = (in_xfer && !tx_full) ? owner_oh_reg : '0;
  assign wr_uart   = beat;
  assign W_data    = beat ? req_bytes[grant_reg] : '0;
  assign busy      = in_xfer;
  assign grant_id  = in_xfer ? grant_reg : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = count_width(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_reg, stall_next;
  logic               timeout_err_reg;

  // The cycle that would bring the stall count to TIMEOUT_CYCLES releases.
  assign timeout_hit = in_xfer && !owner_valid && (stall_reg == STALL_LIMIT);

  // Count owner-silent XFER cycles; tx_full stalls with valid high do not count.
  always_comb begin
    stall_next = stall_reg;
    if (!in_xfer || beat || timeout_hit) begin
      stall_next = '0;
    end else if (!owner_valid) begin
      stall_next = stall_reg + 1'b1;
    end
  end

  // Stall counter and the one-cycle timeout pulse.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      stall_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      stall_reg       <= stall_next;
      timeout_err_reg <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: grant in IDLE, count beats and release in XFER.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_oh_next = owner_oh_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next    = XFER;
          grant_next    = pick_idx;
          owner_oh_next = pick_oh;
          count_next    = '0;
        end
      end
      XFER: begin
        if (beat) begin
          count_next = count_reg + 1'b1;
        end
        if (release_grant) begin
          state_next = IDLE;
          ptr_next   = ptr_after;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM, owner, pointer and beat-count registers.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_oh_reg <= '0;
      ptr_reg      <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_oh_reg <= owner_oh_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are modelled as byte
// queues; a transaction-level model turns the queued messages into the
// expected sequence of UART writes (owner id + byte), which every observed
// wr_uart beat is checked against. Build with UART_ARB_TIMEOUT_EN to also
// exercise the stall timeout.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic             UCLK = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    W_data;
  logic             wr_uart;
  logic             tx_full;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  always #5 UCLK = ~UCLK;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .UCLK      (UCLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .W_data    (W_data),
    .wr_uart   (wr_uart),
    .tx_full   (tx_full),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  typedef struct packed {
    logic       first;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] src_q [NR][$];   // {last, data} per requester
  exp_t       exp_q [$];
  int         wr_cyc [$];
  int         cyc;
  logic       had_write;
  logic       saw_idle;
  int         to_pulses;
  int         to_cyc;

  // Present each requester's queue head on the request bus.
  task automatic drive_inputs();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = h[7:0];
        req_last[i]           = h[8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_exp(input logic first, input int id, input logic [7:0] data);
    exp_t e;
    e.first = first;
    e.id    = id[1:0];
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Transaction-level arbitration: starting at pointer 0, hand the UART to the
  // first requester with data (wrapping), take its bytes until a last byte or
  // MB bytes, then move the pointer past that owner.
  task automatic build_model();
    logic [8:0] mq [NR][$];
    int         ptr;
    int         owner;
    int         n;
    logic [8:0] b;
    logic       done;
    logic       more;
    for (int i = 0; i < NR; i++) mq[i] = src_q[i];
    ptr  = 0;
    more = 1'b1;
    while (more) begin
      owner = -1;
      for (int k = 0; k < NR; k++) begin
        if (owner < 0 && mq[(ptr + k) % NR].size() > 0) owner = (ptr + k) % NR;
      end
      if (owner < 0) begin
        more = 1'b0;
      end else begin
        n    = 0;
        done = 1'b0;
        while (!done && mq[owner].size() > 0) begin
          b = mq[owner].pop_front();
          push_exp(n == 0, owner, b[7:0]);
          n++;
          if (b[8] || n == MB) done = 1'b1;
        end
        ptr = (owner + 1) % NR;
      end
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then apply the
  // handshake to the source queues and drive the next cycle's inputs.
  task automatic step_cycle(input logic txf);
    logic [NR-1:0] acc;
    exp_t          e;
    @(negedge UCLK);
    if (tx_full === 1'b1) begin
      n_cmp++;
      if (req_ready !== '0 || wr_uart !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_quiet: cyc=%0d got req_ready=%b wr_uart=%b, required 0000/0",
                 cyc, req_ready, wr_uart);
      end
    end
    if (wr_uart === 1'b1) begin
      wr_cyc.push_back(cyc);
      $display("write cyc=%0d id=%0d data=%h", cyc, grant_id, W_data);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_write: cyc=%0d got W_data=%h grant_id=%0d, required no write",
                 cyc, W_data, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (W_data !== e.data || grant_id !== e.id || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL write_beat: cyc=%0d got W_data=%h grant_id=%0d busy=%b, required W_data=%h grant_id=%0d busy=1",
                   cyc, W_data, grant_id, busy, e.data, e.id);
        end
        if (e.first && had_write) begin
          n_cmp++;
          if (!saw_idle) begin
            n_fail++;
            $display("FAIL idle_gap: cyc=%0d got no idle cycle before new grant, required one", cyc);
          end
        end
      end
      had_write = 1'b1;
      saw_idle  = 1'b0;
    end
    if (busy === 1'b0) saw_idle = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    if (timeout_err === 1'b1) begin
      to_pulses++;
      to_cyc = cyc;
    end
`endif
    acc = req_valid & req_ready;
    @(posedge UCLK);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    cyc++;
    tx_full = txf;
    drive_inputs();
  endtask

  task automatic start_test();
    #1 reset = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    wr_cyc.delete();
    had_write = 1'b0;
    saw_idle  = 1'b0;
    to_pulses = 0;
    to_cyc    = -1;
    tx_full   = 1'b0;
    drive_inputs();
    @(posedge UCLK);
    #1;
  endtask

  task automatic release_reset();
    drive_inputs();
    @(posedge UCLK);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic drain(input int budget, input bit rand_full);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step_cycle(rand_full ? ($urandom_range(0, 3) == 0) : 1'b0);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d writes outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
    end
    step_cycle(1'b0);
    step_cycle(1'b0);
  endtask

  task automatic test_reset();
    start_test();
    src_q[1].push_back({1'b1, 8'h5A});
    drive_inputs();
    @(negedge UCLK);
    n_cmp++;
    if ({busy, wr_uart, req_ready, grant_id, W_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b wr=%b ready=%b gid=%0d data=%h, required all 0",
               busy, wr_uart, req_ready, grant_id, W_data);
    end
    build_model();
    release_reset();
    drain(20, 1'b0);
    n_cmp++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != 1) begin
      n_fail++;
      $display("FAIL first_latency: got %0d writes first at cyc %0d, required 1 write at cyc 1",
               wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1);
    end
  endtask

  task automatic test_single_message();
    start_test();
    src_q[2].push_back({1'b0, 8'h41});
    src_q[2].push_back({1'b0, 8'h42});
    src_q[2].push_back({1'b1, 8'h43});
    build_model();
    release_reset();
    drain(20, 1'b0);
    n_cmp++;
    if (wr_cyc.size() != 3 || wr_cyc[0] != 1 || wr_cyc[1] != 2 || wr_cyc[2] != 3) begin
      n_fail++;
      $display("FAIL single_timing: got %0d writes starting cyc %0d, required writes at cyc 1,2,3",
               wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1);
    end
    n_cmp++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b grant_id=%0d, required busy=0 grant_id=0", busy, grant_id);
    end
  endtask

  task automatic test_round_robin();
    start_test();
    for (int m = 0; m < 2; m++) begin
      src_q[0].push_back({1'b1, 8'($urandom)});
      src_q[1].push_back({1'b1, 8'($urandom)});
      src_q[3].push_back({1'b1, 8'($urandom)});
    end
    build_model();
    release_reset();
    drain(40, 1'b0);
    for (int i = 0; i < wr_cyc.size(); i++) begin
      n_cmp++;
      if (wr_cyc[i] != 1 + 2 * i) begin
        n_fail++;
        $display("FAIL rr_spacing: write %0d got cyc %0d, required cyc %0d", i, wr_cyc[i], 1 + 2 * i);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    start_test();
    for (int b = 0; b < 4; b++) src_q[1].push_back({b == 3, 8'h60 + 8'(b)});
    src_q[2].push_back({1'b0, 8'h70});
    src_q[2].push_back({1'b1, 8'h71});
    build_model();
    release_reset();
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      step_cycle(k >= 1 && k < 6);
      k++;
    end
    drain(10, 1'b0);
    n_cmp++;
    if (wr_cyc.size() != 6 || wr_cyc[1] != 7) begin
      n_fail++;
      $display("FAIL bp_resume: got %0d writes, second at cyc %0d, required 6 writes, second at cyc 7",
               wr_cyc.size(), (wr_cyc.size() > 1) ? wr_cyc[1] : -1);
    end
  endtask

  task automatic test_fairness();
    start_test();
    for (int b = 0; b < 10; b++) src_q[0].push_back({b == 9, 8'h80 + 8'(b)});
    for (int b = 0; b < 3; b++)  src_q[1].push_back({b == 2, 8'h90 + 8'(b)});
    build_model();
    release_reset();
    drain(60, 1'b0);
    n_cmp++;
    if (wr_cyc.size() != 13 || wr_cyc[4] != 6) begin
      n_fail++;
      $display("FAIL fair_timing: got %0d writes, fifth at cyc %0d, required 13 writes, fifth at cyc 6",
               wr_cyc.size(), (wr_cyc.size() > 4) ? wr_cyc[4] : -1);
    end
  endtask

  task automatic test_random();
    int nmsg;
    int len;
    for (int r = 0; r < 4; r++) begin
      start_test();
      for (int i = 0; i < NR; i++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_model();
      release_reset();
      drain(600, 1'b1);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    start_test();
    src_q[2].push_back({1'b1, 8'hA0});
    for (int b = 0; b < 5; b++) src_q[3].push_back({b == 4, 8'hB0 + 8'(b)});
    build_model();
    release_reset();
    k = 0;
    while (wr_cyc.size() < 3 && k < 30) begin
      step_cycle(1'b0);
      k++;
    end
    n_cmp++;
    if (wr_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL abort_setup: got %0d writes before abort, required 3", wr_cyc.size());
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, wr_uart, req_ready, grant_id, W_data} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b wr=%b ready=%b gid=%0d data=%h, required all 0",
               busy, wr_uart, req_ready, grant_id, W_data);
    end
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    wr_cyc.delete();
    had_write = 1'b0;
    saw_idle  = 1'b0;
    src_q[3].push_back({1'b1, 8'hC0});
    src_q[0].push_back({1'b0, 8'hD0});
    src_q[0].push_back({1'b1, 8'hD1});
    for (int s = 0; s < 3; s++) step_cycle(1'b0);
    build_model();
    release_reset();
    drain(30, 1'b0);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    start_test();
    src_q[0].push_back({1'b0, 8'h10});
    src_q[1].push_back({1'b1, 8'h20});
    push_exp(1'b1, 0, 8'h10);
    push_exp(1'b1, 1, 8'h20);
    release_reset();
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      step_cycle(1'b0);
      k++;
    end
    drain(5, 1'b0);
    n_cmp++;
    if (to_pulses != 1 || to_cyc != 10) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %0d pulses last at cyc %0d, required 1 pulse at cyc 10",
               to_pulses, to_cyc);
    end
    n_cmp++;
    if (wr_cyc.size() != 2 || wr_cyc[1] != 11) begin
      n_fail++;
      $display("FAIL timeout_regrant: got %0d writes, second at cyc %0d, required 2 writes, second at cyc 11",
               wr_cyc.size(), (wr_cyc.size() > 1) ? wr_cyc[1] : -1);
    end
  endtask
`else
  task automatic test_hold_on_drop();
    start_test();
    src_q[0].push_back({1'b0, 8'h10});
    src_q[1].push_back({1'b1, 8'h20});
    push_exp(1'b1, 0, 8'h10);
    push_exp(1'b0, 0, 8'h11);
    push_exp(1'b1, 1, 8'h20);
    release_reset();
    for (int s = 0; s < 15; s++) step_cycle(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || wr_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL hold_grant: got busy=%b grant_id=%0d writes=%0d, required busy=1 grant_id=0 writes=1",
               busy, grant_id, wr_cyc.size());
    end
    src_q[0].push_back({1'b1, 8'h11});
    drive_inputs();
    drain(20, 1'b0);
  endtask
`endif

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    cyc       = 0;
    had_write = 1'b0;
    saw_idle  = 1'b0;
    to_pulses = 0;
    to_cyc    = -1;
    test_reset();
    test_single_message();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_abort();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_on_drop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
